serial_word_comparator: RTL and testbench

SERIAL_WORD_COMPARATOR -- requirements
Module: serial_word_comparator

---
 rtl/serial_word_comparator.sv | 165 ++++++++++++++++
 tb/tb_serial_word_comparator.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_comparator.sv
// ---------------------------------------------------------------------------
// serial_word_comparator
//
// Purpose:
//   Compares two operands A and B that arrive one DIGIT_W-bit digit per beat.
//   A word is WORD_DIGITS digits long. The digits can arrive most significant
//   first (MSB_FIRST=1) or least significant first (MSB_FIRST=0).
//   The running flags give the LT/EQ/GT result over the digits of the current
//   word seen so far. The res_* flags capture the final result of each
//   completed word. A 'first' that arrives in the middle of a word abandons
//   that word and raises a one-cycle frame_err.
//
// Parameters:
//   DIGIT_W      bits per digit (>= 1)
//   WORD_DIGITS  digits per word (>= 2)
//   MSB_FIRST    1: digit 0 is the most significant digit
//                0: digit 0 is the least significant digit
//
// Ports:
//   clk                          clock; all state changes on the rising edge
//   rst                          asynchronous, active-low reset
//   valid_in                     a beat is accepted at a rising edge while high
//   first                        marks digit 0 of a new word
//   signed_i                     two's-complement compare; sampled on digit 0
//   a, b                         operand digits
//   a_less_b/a_eq_b/a_greater_b  running result (one-hot, registered)
//   res_valid                    one-cycle pulse when a word completes
//   res_lt/res_eq/res_gt         final result of the last completed word
//   frame_err                    one-cycle pulse when a partial word is aborted
// ---------------------------------------------------------------------------
module serial_word_comparator #(
  parameter int DIGIT_W     = 1,
  parameter int WORD_DIGITS = 16,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  input  logic               first,
  input  logic               signed_i,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic               a_less_b,
  output logic               a_eq_b,
  output logic               a_greater_b,
  output logic               res_valid,
  output logic               res_lt,
  output logic               res_eq,
  output logic               res_gt,
  output logic               frame_err
);

  localparam int CNT_W = $clog2(WORD_DIGITS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_DIGITS - 1);
  // The sign lives in the most significant digit. That is the first digit
  // when MSB_FIRST=1 and the last digit when MSB_FIRST=0.
  localparam logic [CNT_W-1:0] SIGN_IDX = MSB_FIRST ? '0 : LAST_IDX;
  localparam logic [DIGIT_W-1:0] SIGN_MASK = DIGIT_W'(1) << (DIGIT_W - 1);

  // Each bit of the encoding drives one output flag directly,
  // so the flags are one-hot by construction.
  typedef enum logic [2:0] {
    CMP_LT = 3'b001,
    CMP_EQ = 3'b010,
    CMP_GT = 3'b100
  } cmp_t;

  // Registered state
  logic [CNT_W-1:0] cnt_reg;
  cmp_t             state_reg;
  cmp_t             res_reg;
  logic             signed_reg;
  logic             res_valid_reg;
  logic             frame_err_reg;

  // Next-state / datapath signals
  logic             word_start;
  logic [CNT_W-1:0] digit_idx;
  logic             signed_eff;
  logic             invert_sign;
  logic             last_digit;
  logic [CNT_W-1:0] cnt_next;
  logic [DIGIT_W-1:0] a_eff;
  logic [DIGIT_W-1:0] b_eff;
  cmp_t             prior_state;
  cmp_t             digit_res;
  cmp_t             state_next;

  // Signed compare: flip the MSB of the sign digit. An unsigned compare then
  // orders two's-complement values correctly. Only the bit selected by
  // SIGN_MASK can flip.
  for (genvar gi = 0; gi < DIGIT_W; gi++) begin : g_sign_flip
    assign a_eff[gi] = a[gi] ^ (invert_sign & SIGN_MASK[gi]);
    assign b_eff[gi] = b[gi] ^ (invert_sign & SIGN_MASK[gi]);
  end

  always_comb begin
    // A 'first' always restarts at digit 0, even in the middle of a word.
    word_start  = (cnt_reg == '0) || first;
    digit_idx   = word_start ? '0 : cnt_reg;
    // On digit 0 the sign mode comes straight from the input. After that it
    // comes from the latched copy.
    signed_eff  = word_start ? signed_i : signed_reg;
    invert_sign = signed_eff && (digit_idx == SIGN_IDX);
    last_digit  = (digit_idx == LAST_IDX);
    cnt_next    = last_digit ? '0 : digit_idx + CNT_W'(1);
    prior_state = word_start ? CMP_EQ : state_reg;

    if (a_eff < b_eff) begin
      digit_res = CMP_LT;
    end else if (a_eff > b_eff) begin
      digit_res = CMP_GT;
    end else begin
      digit_res = CMP_EQ;
    end

    if (MSB_FIRST) begin
      // The first differing digit decides the word. Later digits only
      // matter while the state is still EQ.
      state_next = (prior_state == CMP_EQ) ? digit_res : prior_state;
    end else begin
      // Each non-equal digit is more significant than everything before it,
      // so it overrides the state.
      state_next = (digit_res == CMP_EQ) ? prior_state : digit_res;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg       <= '0;
      state_reg     <= CMP_EQ;
      res_reg       <= CMP_EQ;
      signed_reg    <= 1'b0;
      res_valid_reg <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      res_valid_reg <= 1'b0;
      frame_err_reg <= 1'b0;
      if (valid_in) begin
        cnt_reg   <= cnt_next;
        state_reg <= state_next;
        if (word_start) begin
          signed_reg <= signed_i;
        end
        // A first=1 that lands on cnt==0 is a normal start, including the
        // beat right after the last digit of the previous word.
        frame_err_reg <= first && (cnt_reg != '0);
        if (last_digit) begin
          res_reg       <= state_next;
          res_valid_reg <= 1'b1;
        end
      end
    end
  end

  assign a_less_b    = state_reg[0];
  assign a_eq_b      = state_reg[1];
  assign a_greater_b = state_reg[2];
  assign res_lt      = res_reg[0];
  assign res_eq      = res_reg[1];
  assign res_gt      = res_reg[2];
  assign res_valid   = res_valid_reg;
  assign frame_err   = frame_err_reg;

endmodule

// File: tb/tb_serial_word_comparator.sv
// ---------------------------------------------------------------------------
// tb_serial_word_comparator
//
// Drives one digit stream into two comparators with 4-bit digits and 4-digit
// words: one is MSB-first and one is LSB-first.
//
// The driver computes the expected result for each beat and queues it. The
// reference model compares whole integers: prefixes for MSB-first, low-order
// parts for LSB-first, with sign extension in signed mode.
//
// A monitor pops one entry from the queue per accepted beat. It checks every
// output one cycle later. On cycles without a beat it checks that the state
// holds and that no pulse appears.
// ---------------------------------------------------------------------------
module tb_serial_word_comparator;

  localparam int DW = 4;
  localparam int WD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid_in = 1'b0;
  logic first = 1'b0;
  logic signed_i = 1'b0;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;

  logic m_lt, m_eq, m_gt, m_rv, m_rlt, m_req, m_rgt, m_fe;
  logic l_lt, l_eq, l_gt, l_rv, l_rlt, l_req, l_rgt, l_fe;

  always #5 clk = ~clk;

  serial_word_comparator #(.DIGIT_W(DW), .WORD_DIGITS(WD), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .valid_in(valid_in), .first(first), .signed_i(signed_i),
    .a(a), .b(b),
    .a_less_b(m_lt), .a_eq_b(m_eq), .a_greater_b(m_gt),
    .res_valid(m_rv), .res_lt(m_rlt), .res_eq(m_req), .res_gt(m_rgt),
    .frame_err(m_fe)
  );

  serial_word_comparator #(.DIGIT_W(DW), .WORD_DIGITS(WD), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .valid_in(valid_in), .first(first), .signed_i(signed_i),
    .a(a), .b(b),
    .a_less_b(l_lt), .a_eq_b(l_eq), .a_greater_b(l_gt),
    .res_valid(l_rv), .res_lt(l_rlt), .res_eq(l_req), .res_gt(l_rgt),
    .frame_err(l_fe)
  );

  // Flag encoding used by the bench: {gt, eq, lt}
  localparam logic [2:0] F_LT = 3'b001;
  localparam logic [2:0] F_EQ = 3'b010;
  localparam logic [2:0] F_GT = 3'b100;

  typedef struct packed {
    logic [2:0] run_m;
    logic [2:0] run_l;
    logic [2:0] res_m;
    logic [2:0] res_l;
    logic       rv;
    logic       fe;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Digit i of a word is kept in nibble i of a 16-bit vector.
  int          m_cnt = 0;
  logic [15:0] wa_m = '0;
  logic [15:0] wb_m = '0;
  bit          m_sgn = 1'b0;
  logic [2:0]  m_res_m = F_EQ;
  logic [2:0]  m_res_l = F_EQ;

  function automatic logic [2:0] cmp3(input longint x, input longint y);
    if (x < y) return F_LT;
    if (x > y) return F_GT;
    return F_EQ;
  endfunction

  // MSB first: the first k digits form the top k*4 bits of the word.
  // The sign is the MSB of digit 0.
  function automatic longint msb_val(input logic [15:0] w, input int k, input bit sg);
    longint v = 0;
    for (int i = 0; i < k; i++) v = v * 16 + longint'(w[4*i +: 4]);
    if (sg && w[3]) v = v - (longint'(1) << (4 * k));
    return v;
  endfunction

  // LSB first: the first k digits form the low k*4 bits.
  // The sign only exists once the whole word is in.
  function automatic longint lsb_val(input logic [15:0] w, input int k, input bit sg);
    longint v = longint'(w) & ((longint'(1) << (4 * k)) - 1);
    if (sg && k == WD && w[15]) v = v - 65536;
    return v;
  endfunction

  task automatic model_beat(input logic [3:0] av, input logic [3:0] bv,
                            input bit f, input bit s);
    exp_t e;
    int   idx;
    bit   ws;
    ws   = (m_cnt == 0) || f;
    e.fe = f && (m_cnt != 0);
    if (ws) begin
      idx   = 0;
      m_sgn = s;
      wa_m  = '0;
      wb_m  = '0;
    end else begin
      idx = m_cnt;
    end
    wa_m[4*idx +: 4] = av;
    wb_m[4*idx +: 4] = bv;
    e.run_m = cmp3(msb_val(wa_m, idx + 1, m_sgn), msb_val(wb_m, idx + 1, m_sgn));
    e.run_l = cmp3(lsb_val(wa_m, idx + 1, m_sgn), lsb_val(wb_m, idx + 1, m_sgn));
    e.rv = (idx == WD - 1);
    if (e.rv) begin
      m_res_m = e.run_m;
      m_res_l = e.run_l;
    end
    e.res_m = m_res_m;
    e.res_l = m_res_l;
    m_cnt = e.rv ? 0 : idx + 1;
    exp_q.push_back(e);
  endtask

  // ---------------- driver helpers ----------------
  // Idle cycle. Junk on the data inputs must be ignored while valid_in=0.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid_in = 1'b0;
      a        = 4'($urandom);
      b        = 4'($urandom);
      first    = 1'($urandom);
      signed_i = 1'($urandom);
    end
  endtask

  task automatic beat(input logic [3:0] av, input logic [3:0] bv,
                      input bit f, input bit s, input int gap);
    @(negedge clk);
    valid_in = 1'b1;
    a        = av;
    b        = bv;
    first    = f;
    signed_i = s;
    model_beat(av, bv, f, s);
    idle(gap);
  endtask

  // Words are written with digit 0 as the leftmost hex digit.
  task automatic send_word(input logic [15:0] wa, input logic [15:0] wb,
                           input bit s, input int gap);
    for (int i = 0; i < WD; i++) begin
      beat(wa[15-4*i -: 4], wb[15-4*i -: 4], i == 0, s, gap);
    end
  endtask

  // ---------------- monitor ----------------
  exp_t hold;
  exp_t mon_e;
  int   cyc = 0;
  int   rv_times[$];
  logic beat_s;
  logic rst_s;
  logic [3:0] a_s;
  logic [3:0] b_s;

  always @(posedge clk) begin
    beat_s = valid_in && rst;
    rst_s  = rst;
    a_s    = a;
    b_s    = b;
    cyc++;
    #1;
    if (!rst_s || !rst) begin
      hold = '{run_m: F_EQ, run_l: F_EQ, res_m: F_EQ, res_l: F_EQ, rv: 1'b0, fe: 1'b0};
    end else begin
      if (beat_s) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          hold  = mon_e;
          $display("beat cyc=%0d a=%h b=%h run_m=%b run_l=%b rv=%b fe=%b res_m=%b res_l=%b",
                   cyc, a_s, b_s, mon_e.run_m, mon_e.run_l, mon_e.rv, mon_e.fe,
                   mon_e.res_m, mon_e.res_l);
        end
      end else begin
        hold.rv = 1'b0;
        hold.fe = 1'b0;
      end
      chk("run_msb", {29'd0, m_gt, m_eq, m_lt}, {29'd0, hold.run_m});
      chk("run_lsb", {29'd0, l_gt, l_eq, l_lt}, {29'd0, hold.run_l});
      chk("res_msb", {29'd0, m_rgt, m_req, m_rlt}, {29'd0, hold.res_m});
      chk("res_lsb", {29'd0, l_rgt, l_req, l_rlt}, {29'd0, hold.res_l});
      chk("res_valid_msb", {31'd0, m_rv}, {31'd0, hold.rv});
      chk("res_valid_lsb", {31'd0, l_rv}, {31'd0, hold.rv});
      chk("frame_err_msb", {31'd0, m_fe}, {31'd0, hold.fe});
      chk("frame_err_lsb", {31'd0, l_fe}, {31'd0, hold.fe});
      if (m_rv) rv_times.push_back(cyc);
    end
  end

  // Checks that both comparators show their reset values right now.
  task automatic chk_reset_outputs(input string name);
    chk({name, "_msb"}, {24'd0, m_lt, m_eq, m_gt, m_rv, m_rlt, m_req, m_rgt, m_fe},
        32'b0100_0100);
    chk({name, "_lsb"}, {24'd0, l_lt, l_eq, l_gt, l_rv, l_rlt, l_req, l_rgt, l_fe},
        32'b0100_0100);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    bit       f;
    bit       s;
    bit [3:0] av;
    bit [3:0] bv;
    int       gap;

    // Power-up reset: a real falling edge on rst must clear the outputs
    // without any clock edge.
    #2 rst = 1'b0;
    #1 chk_reset_outputs("reset_initial");
    idle(3);
    @(negedge clk) rst = 1'b1;
    idle(2);

    // MSB-first vectors
    send_word(16'h6482, 16'h6262, 1'b0, 0);
    send_word(16'h8000, 16'h0001, 1'b1, 0);
    send_word(16'h8000, 16'h0001, 1'b0, 0);
    idle(2);

    // LSB-first vectors (digit streams 2,8,4,6 / 2,6,2,6 and 6,3,2,1 / 5,3,2,1)
    send_word(16'h2846, 16'h2626, 1'b0, 0);
    send_word(16'h6321, 16'h5321, 1'b0, 0);
    idle(1);

    // Abort on beat 3, then three more beats complete the new word
    beat(4'h1, 4'h0, 1'b1, 1'b0, 0);
    beat(4'h2, 4'h2, 1'b0, 1'b0, 0);
    beat(4'h3, 4'h3, 1'b1, 1'b1, 0);
    beat(4'h4, 4'h4, 1'b0, 1'b0, 0);
    beat(4'h5, 4'h5, 1'b0, 1'b0, 0);
    beat(4'h6, 4'h7, 1'b0, 1'b0, 0);
    idle(2);

    // Same vector with gaps between beats
    send_word(16'h6482, 16'h6262, 1'b0, 1);
    idle(2);

    // Back-to-back words: res_valid pulses exactly WD cycles apart
    rv_times.delete();
    send_word(16'hF123, 16'h0123, 1'b1, 0);
    send_word(16'h1234, 16'h1243, 1'b0, 0);
    idle(3);
    chk("b2b_pulse_count", rv_times.size(), 32'd2);
    if (rv_times.size() >= 2) begin
      chk("b2b_spacing", rv_times[rv_times.size()-1] - rv_times[rv_times.size()-2], WD);
    end

    // Reset mid-word, asserted between edges. The outputs must clear at once.
    // Beats offered while in reset must be ignored.
    beat(4'h9, 4'h1, 1'b1, 1'b0, 0);
    beat(4'h2, 4'h3, 1'b0, 1'b0, 0);
    @(negedge clk);
    valid_in = 1'b0;
    #2 rst = 1'b0;
    #1 chk_reset_outputs("reset_async");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      valid_in = 1'b1;
      a        = 4'hF;
      b        = 4'h0;
      first    = (i == 1);
      signed_i = 1'b0;
    end
    @(negedge clk);
    valid_in = 1'b0;
    rst      = 1'b1;
    m_cnt    = 0;
    m_res_m  = F_EQ;
    m_res_l  = F_EQ;
    idle(2);
    // The first beat after release is digit 0 even with first=0
    beat(4'h0, 4'h1, 1'b0, 1'b0, 0);
    beat(4'h5, 4'h5, 1'b0, 1'b0, 0);
    beat(4'h5, 4'h5, 1'b0, 1'b0, 0);
    beat(4'h5, 4'h4, 1'b0, 1'b0, 0);
    idle(2);

    // Randomized traffic: equal-digit bias, single-bit differences,
    // occasional aborts and gaps
    for (int n = 0; n < 300; n++) begin
      f  = (m_cnt == 0) ? 1'($urandom) : ($urandom_range(0, 11) == 0);
      s  = 1'($urandom);
      av = 4'($urandom);
      case ($urandom_range(0, 2))
        0:       bv = av;
        1:       bv = av ^ (4'd1 << $urandom_range(0, 3));
        default: bv = 4'($urandom);
      endcase
      gap = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 2) : 0;
      beat(av, bv, f, s, gap);
    end
    idle(4);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
